// File: rtl/prog_loader_if.sv
// -----------------------------------------------------------------------------
// prog_loader_if
// Bundles the two buses of the program loader:
//   stream side : in_data / in_valid (host -> loader), in_ready (loader -> host)
//   RAM side    : mem_we / mem_addr / mem_data (loader -> RAM write port)
// Modports:
//   master : host/testbench view (drives the stream, observes the RAM writes)
//   slave  : loader view (consumes the stream, drives the RAM writes)
// -----------------------------------------------------------------------------
interface prog_loader_if #(
    parameter int ADDR_W = 4
);
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_data;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_data
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output mem_we,
        output mem_addr,
        output mem_data
    );
endinterface

// File: rtl/prog_loader.sv
// -----------------------------------------------------------------------------
// prog_loader
// Byte-serial program loader. Holds the CPU, takes a framed image
// (length, data bytes, 8-bit checksum) over a valid/ready stream, writes the
// data into RAM from address 0 and, if the checksum matches, releases the CPU
// with a one-cycle reset_cycle pulse.
//
// Ports:
//   clk          system clock, posedge
//   reset        synchronous, active-high
//   load_start   one-cycle request to start a load (honoured in IDLE / ERROR)
//   bus          prog_loader_if.slave: stream in, RAM write port out
//                (mem_* registered, in_ready combinational from state)
//   cpu_hold     CPU frozen / RAM port muxed to the loader
//   reset_cycle  one-cycle pulse restarting the CPU sequencer
//   busy         load in progress (LEN, DATA, CSUM, RELEASE)
//   done         sticky: last load succeeded
//   error        sticky: last load failed
//
// state   | meaning
// --------+-------------------------------------------------
// IDLE    | CPU running, waiting for load_start
// LEN     | waiting for the length byte
// DATA    | accepting data bytes, one RAM write per byte
// CSUM    | waiting for the checksum byte
// RELEASE | one cycle: pulse reset_cycle, then back to IDLE
// ERROR   | bad length or checksum; CPU held until load_start
// -----------------------------------------------------------------------------
module prog_loader #(
    parameter int ADDR_W = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_start,
    prog_loader_if.slave  bus,
    output logic          cpu_hold,
    output logic          reset_cycle,
    output logic          busy,
    output logic          done,
    output logic          error
);
    // 9 bits so that DEPTH = 256 (ADDR_W = 8) is still representable.
    localparam logic [8:0] DEPTH = 9'(1 << ADDR_W);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN, S_DATA, S_CSUM, S_RELEASE, S_ERROR
    } state_t;

    state_t            state, state_nx;
    logic [8:0]        remaining;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        checksum;
    logic              accept;
    logic [8:0]        len_ext;

    assign accept  = bus.in_valid & bus.in_ready;
    assign len_ext = {1'b0, bus.in_data};

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:    if (load_start) state_nx = S_LEN;
            S_LEN:     if (accept)
                           state_nx = (len_ext == 9'd0 || len_ext > DEPTH) ? S_ERROR : S_DATA;
            S_DATA:    if (accept && remaining == 9'd1) state_nx = S_CSUM;
            S_CSUM:    if (accept)
                           state_nx = (bus.in_data == checksum) ? S_RELEASE : S_ERROR;
            S_RELEASE: state_nx = S_IDLE;
            S_ERROR:   if (load_start) state_nx = S_LEN;
            default:   state_nx = S_IDLE;
        endcase
    end

    // error is a pure state decode: ERROR is only left via load_start (which
    // clears it anyway) or reset, so it is sticky without a register.
    always_comb begin
        bus.in_ready = (state == S_LEN) || (state == S_DATA) || (state == S_CSUM);
        cpu_hold     = (state != S_IDLE);
        reset_cycle  = (state == S_RELEASE);
        busy         = (state != S_IDLE) && (state != S_ERROR);
        error        = (state == S_ERROR);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            remaining    <= '0;
            addr         <= '0;
            checksum     <= '0;
            bus.mem_we   <= 1'b0;
            bus.mem_addr <= '0;
            bus.mem_data <= '0;
            done         <= 1'b0;
        end else begin
            bus.mem_we <= 1'b0;
            if ((state == S_IDLE || state == S_ERROR) && load_start) begin
                checksum <= '0;
                addr     <= '0;
                done     <= 1'b0;
            end
            if (state == S_LEN && accept) begin
                remaining <= len_ext;
                addr      <= '0;
            end
            if (state == S_DATA && accept) begin
                bus.mem_we   <= 1'b1;
                bus.mem_addr <= addr;
                bus.mem_data <= bus.in_data;
                // addr wraps only after the very last byte of a DEPTH-long
                // image, when it is no longer used.
                addr         <= addr + ADDR_W'(1);
                checksum     <= checksum + bus.in_data;
                remaining    <= remaining - 9'd1;
            end
            if (state == S_RELEASE) done <= 1'b1;
        end
    end
endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;
    logic clk = 1'b0;
    logic reset, load_start;
    logic cpu_hold, reset_cycle, busy, done, error;

    prog_loader_if #(.ADDR_W(4)) bus();

    prog_loader #(.ADDR_W(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .load_start  (load_start),
        .bus         (bus),
        .cpu_hold    (cpu_hold),
        .reset_cycle (reset_cycle),
        .busy        (busy),
        .done        (done),
        .error       (error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int rc_cycles = 0;

    always @(negedge clk) if (reset_cycle === 1'b1) rc_cycles++;

    typedef struct {
        string        name;
        logic [7:0]   len;
        logic [127:0] data;
        logic [7:0]   csum;
        int           stall;
        bit           exp_done;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_write(input bit pend, input logic [7:0] pa, input logic [7:0] pd);
        chk("mem_we", 32'(bus.mem_we), 32'(pend));
        if (pend) begin
            chk("mem_addr", 32'(bus.mem_addr), 32'(pa[3:0]));
            chk("mem_data", 32'(bus.mem_data), 32'(pd));
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        chk("start_busy",     32'(busy),         32'd1);
        chk("start_error",    32'(error),        32'd0);
        chk("start_done",     32'(done),         32'd0);
        chk("start_cpu_hold", 32'(cpu_hold),     32'd1);
        chk("start_in_ready", 32'(bus.in_ready), 32'd1);
    endtask

    // Offers bytes b[] one by one; the bytes at indices first..first+n-1 are
    // data bytes expected in RAM at addr_base onward, one cycle after accept.
    // stall: 0 = always valid, 1 = valid every other cycle, 2 = random.
    task automatic drive_bytes(input logic [7:0] b[$], input int first, input int n,
                               input int addr_base, input int stall);
        int idx = 0;
        int cyc = 0;
        bit pend = 1'b0;
        bit v;
        logic [7:0] pa = '0;
        logic [7:0] pd = '0;
        while (idx < b.size()) begin
            @(negedge clk);
            check_write(pend, pa, pd);
            pend = 1'b0;
            if (cyc > 500) begin
                chk("stream_timeout", 32'(idx), 32'(b.size()));
                break;
            end
            v = (stall == 0) ? 1'b1 : (stall == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
            cyc++;
            bus.in_valid = v;
            bus.in_data  = b[idx];
            if (v && bus.in_ready === 1'b1) begin
                if (idx >= first && idx < first + n) begin
                    pend = 1'b1;
                    pa   = 8'(addr_base + idx - first);
                    pd   = b[idx];
                end
                idx++;
            end
        end
        @(negedge clk);
        check_write(pend, pa, pd);
        bus.in_valid = 1'b0;
    endtask

    task automatic check_end(input bit exp_done, input int rc0);
        repeat (3) @(negedge clk);
        chk("end_done",     32'(done),           32'(exp_done));
        chk("end_error",    32'(error),          32'(!exp_done));
        chk("end_cpu_hold", 32'(cpu_hold),       32'(!exp_done));
        chk("end_busy",     32'(busy),           32'd0);
        chk("end_in_ready", 32'(bus.in_ready),   32'd0);
        chk("end_mem_we",   32'(bus.mem_we),     32'd0);
        chk("end_rc_count", 32'(rc_cycles - rc0), 32'(exp_done));
    endtask

    task automatic run_frame(input logic [7:0] len, input logic [127:0] data,
                             input logic [7:0] csum, input int stall, input bit exp_done);
        logic [7:0] b[$];
        int n_data;
        int rc0;
        n_data = (len != 0 && len <= 16) ? int'(len) : 0;
        b.push_back(len);
        if (n_data > 0) begin
            for (int i = 0; i < n_data; i++) b.push_back(data[i*8 +: 8]);
            b.push_back(csum);
        end
        rc0 = rc_cycles;
        pulse_start();
        drive_bytes(b, 1, n_data, 0, stall);
        check_end(exp_done, rc0);
    endtask

    task automatic check_all_zero(input string nm);
        chk({nm, "_mem_we"},      32'(bus.mem_we),   32'd0);
        chk({nm, "_mem_addr"},    32'(bus.mem_addr), 32'd0);
        chk({nm, "_mem_data"},    32'(bus.mem_data), 32'd0);
        chk({nm, "_cpu_hold"},    32'(cpu_hold),     32'd0);
        chk({nm, "_reset_cycle"}, 32'(reset_cycle),  32'd0);
        chk({nm, "_busy"},        32'(busy),         32'd0);
        chk({nm, "_done"},        32'(done),         32'd0);
        chk({nm, "_error"},       32'(error),        32'd0);
        chk({nm, "_in_ready"},    32'(bus.in_ready), 32'd0);
    endtask

    initial begin
        vec_t vecs[7];
        logic [7:0] q[$];
        int rc0;

        vecs[0] = '{"nominal",   8'h03, 128'h332211, 8'h66, 0, 1'b1};
        vecs[1] = '{"wrap_ok",   8'h02, 128'h02FF,   8'h01, 0, 1'b1};
        vecs[2] = '{"wrap_bad",  8'h02, 128'h02FF,   8'h00, 0, 1'b0};
        vecs[3] = '{"len_zero",  8'h00, 128'h0,      8'h00, 0, 1'b0};
        vecs[4] = '{"len_17",    8'h11, 128'h0,      8'h00, 0, 1'b0};
        vecs[5] = '{"len_16",    8'h10, 128'h0F0E0D0C0B0A09080706050403020100, 8'h78, 0, 1'b1};
        vecs[6] = '{"stall_alt", 8'h03, 128'h332211, 8'h66, 1, 1'b1};

        reset = 1'b1;
        load_start = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_all_zero("reset");

        for (int i = 0; i < 7; i++)
            run_frame(vecs[i].len, vecs[i].data, vecs[i].csum, vecs[i].stall, vecs[i].exp_done);

        // Reset after 2 of 3 data bytes.
        pulse_start();
        q = {};
        q.push_back(8'h03); q.push_back(8'hA1); q.push_back(8'hA2);
        drive_bytes(q, 1, 2, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_all_zero("midreset");
        reset = 1'b0;
        run_frame(8'h03, 128'h332211, 8'h66, 0, 1'b1);

        // load_start during DATA is ignored; image continues at address 1.
        rc0 = rc_cycles;
        pulse_start();
        q = {};
        q.push_back(8'h03); q.push_back(8'h5A);
        drive_bytes(q, 1, 1, 0, 0);
        @(negedge clk);
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        chk("ign_busy",     32'(busy),         32'd1);
        chk("ign_in_ready", 32'(bus.in_ready), 32'd1);
        q = {};
        q.push_back(8'hC3); q.push_back(8'h0F); q.push_back(8'h2C);
        drive_bytes(q, 0, 2, 1, 0);
        check_end(1'b1, rc0);

        // Randomized frames against the arithmetic frame model.
        for (int t = 0; t < 40; t++) begin
            logic [7:0]   len, sum, csum;
            logic [127:0] data;
            bit           ok;
            len = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255))
                                              : 8'($urandom_range(1, 16));
            data = {$urandom, $urandom, $urandom, $urandom};
            sum = 8'h00;
            if (len >= 1 && len <= 16)
                for (int i = 0; i < int'(len); i++) sum = sum + data[i*8 +: 8];
            csum = ($urandom_range(0, 3) == 0) ? (sum ^ 8'($urandom_range(1, 255))) : sum;
            ok = (len >= 1) && (len <= 16) && (csum == sum);
            run_frame(len, data, csum, int'($urandom_range(0, 2)), ok);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
